// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrating mux feeding a single-entry registered output.
// Define RR_ARB_MUX_PRIO_EN to add prio_mask, which restricts arbitration to masked-in requesters.

module rr_arb_mux_lane #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic             gnt,
  output logic [WIDTH-1:0] dout
);
  assign dout = din & {WIDTH{gnt}};
endmodule

module rr_arb_mux #(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
`ifdef RR_ARB_MUX_PRIO_EN
  input  logic [N-1:0]       prio_mask,
`endif
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src,
  output logic               busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  src;
  } resp_t;

  state_t                  state;
  resp_t                   out_q;
  logic [SELW-1:0]         ptr, ptr_nxt;
  logic [N-1:0][WIDTH-1:0] din, lane_q;
  logic [N-1:0]            req, gnt_oh;
  logic                    hi_vld, gnt_vld, accept;
  logic [SELW-1:0]         hi_idx, lo_idx, gnt_idx;
  logic [WIDTH-1:0]        sel_data;

  assign din = in_data;

`ifdef RR_ARB_MUX_PRIO_EN
  // Masked requesters take over arbitration only while at least one of them is valid.
  assign req = (|(in_valid & prio_mask)) ? (in_valid & prio_mask) : in_valid;
`else
  assign req = in_valid;
`endif

  // Round-robin as two priority scans: first requester at/after ptr, else first overall (wrap).
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (req[i]) lo_idx = SELW'(i);
      if (req[i] && (i >= int'(ptr))) begin
        hi_vld = 1'b1;
        hi_idx = SELW'(i);
      end
    end
  end

  assign gnt_vld = |req;
  assign gnt_idx = hi_vld ? hi_idx : lo_idx;
  assign ptr_nxt = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;

  // Refill is allowed when empty or when the held word drains this same cycle.
  assign accept  = gnt_vld && ((state == EMPTY) || out_ready) && !Reset;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign gnt_oh[i] = gnt_vld && (gnt_idx == SELW'(i));
    rr_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .din  (din[i]),
      .gnt  (gnt_oh[i]),
      .dout (lane_q[i])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) sel_data = sel_data | lane_q[i];
  end

  assign in_ready = accept ? gnt_oh : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
      out_q <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (!accept && out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        out_q.data <= sel_data;
        out_q.src  <= gnt_idx;
        ptr        <= ptr_nxt;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign out_data  = out_q.data;
  assign out_src   = out_q.src;
  assign busy      = out_valid || (|in_valid);

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomized + directed bench for rr_arb_mux: spec-level arbitration model feeds a scoreboard queue.
module tb_rr_arb_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready, busy;
  logic [1:0]  out_src;
`ifdef RR_ARB_MUX_PRIO_EN
  logic [3:0]  prio_mask;
  logic [2:0]  t_prio;
`endif
  logic [47:0] t_d;
  logic [2:0]  t_v, t_rdy;
  logic [15:0] t_out;
  logic        t_ov, t_or, t_busy;
  logic [1:0]  t_src;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(16), .N(4)) u4 (
    .Clk(clk), .Reset(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef RR_ARB_MUX_PRIO_EN
    .prio_mask(prio_mask),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src), .busy(busy));

  rr_arb_mux #(.WIDTH(16), .N(3)) u3 (
    .Clk(clk), .Reset(rst), .in_data(t_d), .in_valid(t_v),
`ifdef RR_ARB_MUX_PRIO_EN
    .prio_mask(t_prio),
`endif
    .in_ready(t_rdy), .out_data(t_out), .out_valid(t_ov),
    .out_ready(t_or), .out_src(t_src), .busy(t_busy));

  typedef struct { logic [15:0] d; int s; } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0;
  int   m_ptr = 0, acc_ch = -1;
  bit   m_full = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the next grant is the first valid channel in the circular order starting at ptr.
  initial begin
    int g, c;
    logic [3:0] req, exp_rdy;
    bit allowed;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        m_full = 0; m_ptr = 0; acc_ch = -1; q.delete();
      end else begin
        req = in_valid;
`ifdef RR_ARB_MUX_PRIO_EN
        if ((in_valid & prio_mask) != 4'd0) req = in_valid & prio_mask;
`endif
        g = -1;
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (g < 0 && req[c]) g = c;
        end
        allowed = !m_full || out_ready;
        exp_rdy = (g >= 0 && allowed) ? 4'(1 << g) : 4'd0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("busy", 64'(busy), 64'(m_full || (in_valid != 4'd0)));
        if (g >= 0 && allowed) begin
          exp_t e;
          e.d = in_data[g*16 +: 16];
          e.s = g;
          q.push_back(e);
          m_ptr = (g + 1) % 4; m_full = 1; acc_ch = g;
        end else begin
          acc_ch = -1;
          if (out_ready) m_full = 0;
        end
      end
    end
  end

  // Monitor: every presented word must match the queue head; it is popped only on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) chk("mon_unexpected_word", 64'(out_data), 64'hxxxx);
        else begin
          chk("out_data", 64'(out_data), 64'(q[0].d));
          chk("out_src", 64'(out_src), 64'(q[0].s));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] v, input logic [63:0] d, input logic r);
    @(posedge clk); #1;
    in_valid = v; in_data = d; out_ready = r;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    t_v = '0; t_or = 1'b1; t_d = {16'h00C2, 16'h00B1, 16'h00A0};
`ifdef RR_ARB_MUX_PRIO_EN
    prio_mask = '0; t_prio = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cyc(4'b0000, 64'd0, 1'b1);
    @(negedge clk);
    chk("idle_out_data", 64'(out_data), 64'd0);
    chk("idle_out_src", 64'(out_src), 64'd0);

    repeat (6) cyc(4'b1111, 64'h4444_3333_2222_1111, 1'b1);
    repeat (2) cyc(4'b0000, 64'd0, 1'b1);

    repeat (4) cyc(4'b0100, 64'h0000_BEEF_0000_0000, 1'b0);
    repeat (2) cyc(4'b0100, 64'h0000_BEEF_0000_0000, 1'b1);
    repeat (2) cyc(4'b0000, 64'd0, 1'b1);

    // Park ptr at 2, hold 0x5A5A in the output, then reset mid-transfer.
    cyc(4'b0010, 64'h0000_0000_5A5A_0000, 1'b0);
    cyc(4'b0000, 64'd0, 1'b0);
    @(posedge clk); #1 rst = 1'b1; in_valid = 4'b1111; in_data = 64'h4444_3333_2222_1111;
    @(negedge clk);
    chk("rst_async_drop", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) cyc(4'b1111, 64'h4444_3333_2222_1111, 1'b1);
    repeat (2) cyc(4'b0000, 64'd0, 1'b1);

`ifdef RR_ARB_MUX_PRIO_EN
    prio_mask = 4'b0100;
    repeat (4) cyc(4'b1111, 64'h4444_3333_2222_1111, 1'b1);
    prio_mask = 4'b0000;
    repeat (3) cyc(4'b1111, 64'h4444_3333_2222_1111, 1'b1);
    repeat (2) cyc(4'b0000, 64'd0, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!(in_valid[i] && acc_ch != i)) begin
          in_valid[i] = ($urandom_range(0, 2) != 0);
          in_data[i*16 +: 16] = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_ARB_MUX_PRIO_EN
      prio_mask = 4'($urandom);
`endif
    end
    repeat (4) cyc(4'b0000, 64'd0, 1'b1);
`ifdef RR_ARB_MUX_PRIO_EN
    prio_mask = '0;
`endif

    // N=3 wrap: ch1 first moves ptr to 2, then ch2 wins over ch0 and ptr wraps to 0.
    @(posedge clk); #1 t_v = 3'b010;
    @(negedge clk); chk("n3_rdy_ch1", 64'(t_rdy), 64'b010);
    @(posedge clk); #1 t_v = 3'b101;
    @(negedge clk); chk("n3_rdy_ch2", 64'(t_rdy), 64'b100);
    chk("n3_src_ch1", 64'(t_src), 64'd1);
    @(posedge clk); #1 t_v = 3'b001;
    @(negedge clk); chk("n3_rdy_ch0", 64'(t_rdy), 64'b001);
    chk("n3_src_ch2", 64'(t_src), 64'd2);
    chk("n3_data_ch2", 64'(t_out), 64'h00C2);
    @(posedge clk); #1 t_v = 3'b000;
    @(negedge clk); chk("n3_src_ch0", 64'(t_src), 64'd0);
    chk("n3_data_ch0", 64'(t_out), 64'h00A0);
    chk("n3_valid", 64'(t_ov), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("n3_drained", 64'(t_ov), 64'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
